// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and registers instruction+PC for the decoder.
// Start/jump/halt redirect the stream; a held valid with no ready freezes the stage.
`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif
`ifndef INST_LENGTH
`define INST_LENGTH 8
`endif

module inst_fetch #(
  parameter int                ADDR_W   = `INSTMEM_ADDR_WIDTH,
  parameter int                INST_W   = `INST_LENGTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALTED = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic [ADDR_W-1:0]  inst_pc_q, inst_pc_d;
  logic               vld_q, vld_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      vld_q     <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED: if (start) state_d = FETCH;
      FETCH:        if (halt)  state_d = HALTED;
      default:      state_d = IDLE;
    endcase
  end

  // Halt beats jump beats load; a stalled valid holds everything.
  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    vld_d     = vld_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start) pc_d = RESET_PC;
      end
      FETCH: begin
        if (halt) begin
          vld_d = 1'b0;
        end else if (jump_en) begin
          pc_d  = jump_addr;
          vld_d = 1'b0;
        end else if (!vld_q || inst_ready) begin
          inst_d    = imem_data;
          inst_pc_d = pc_q;
          vld_d     = 1'b1;
          pc_d      = pc_q + 1'b1;
        end
      end
      default: vld_d = 1'b0;
    endcase
  end

  always_comb begin
    busy       = (state_q == FETCH);
    imem_addr  = pc_q;
    inst_out   = inst_q;
    inst_pc    = inst_pc_q;
    inst_valid = vld_q;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios against constants, then random traffic against a behavioural model.
module tb_inst_fetch;
  localparam int AW = 8;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0, start = 1'b0, inst_ready = 1'b0, jump_en = 1'b0, halt = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic [AW-1:0] imem_addr, inst_pc;
  logic [IW-1:0] imem_data, inst_out;
  logic          inst_valid, busy;
  logic [IW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  // Model: fetching or not (IDLE and HALTED look identical from outside), PC, output register, delivered log.
  bit         m_run = 0, m_vld = 0;
  logic [7:0] m_pc = 0, m_ipc = 0, m_out = 0;
  logic [7:0] delivered [$];

  inst_fetch #(.ADDR_W(AW), .INST_W(IW), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt), .busy(busy)
  );

  assign imem_data = mem[imem_addr];
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_run = 0; m_pc = 0; m_vld = 0; m_out = 0; m_ipc = 0;
    end else if (!m_run) begin
      if (start) begin m_run = 1; m_pc = 0; end
    end else if (halt) begin
      m_run = 0; m_vld = 0;
    end else begin
      if (m_vld && inst_ready) delivered.push_back(m_ipc);
      if (jump_en) begin
        m_pc = jump_addr; m_vld = 0;
      end else if (!m_vld || inst_ready) begin
        m_out = mem[m_pc]; m_ipc = m_pc; m_vld = 1; m_pc = m_pc + 8'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", imem_addr); end
    total++; if (inst_out !== 8'h00 || inst_pc !== 8'h00) begin bad++; $display("FAIL reset_regs got=%h/%h exp=00/00", inst_out, inst_pc); end
  endtask

  task automatic test_stream();
    inst_ready = 1; start = 1; tick(); start = 0;
    total++; if (busy !== 1'b1 || inst_valid !== 1'b0) begin bad++; $display("FAIL start_lat1 busy=%b valid=%b exp=1/0", busy, inst_valid); end
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00 || inst_out !== 8'h10) begin bad++; $display("FAIL start_lat2 valid=%b pc=%h inst=%h exp=1/00/10", inst_valid, inst_pc, inst_out); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++; if (inst_pc !== 8'(k) || inst_out !== 8'(k + 16)) begin bad++; $display("FAIL stream_%0d pc=%h inst=%h exp=%h/%h", k, inst_pc, inst_out, 8'(k), 8'(k + 16)); end
    end
  endtask

  task automatic test_stall();
    inst_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h05 || inst_out !== 8'h15 || imem_addr !== 8'h06) begin
        bad++; $display("FAIL stall_hold_%0d valid=%b pc=%h inst=%h addr=%h exp=1/05/15/06", k, inst_valid, inst_pc, inst_out, imem_addr); end
    end
    inst_ready = 1; tick();
    total++; if (inst_pc !== 8'h06 || inst_out !== 8'h16) begin bad++; $display("FAIL stall_release pc=%h inst=%h exp=06/16", inst_pc, inst_out); end
    total++; if (delivered.size() != 6) begin bad++; $display("FAIL stall_count got=%0d exp=6", delivered.size()); end
    else for (int k = 0; k < 6; k++) begin
      total++; if (delivered[k] !== 8'(k)) begin bad++; $display("FAIL stall_order_%0d got=%h exp=%h", k, delivered[k], 8'(k)); end
    end
  endtask

  task automatic test_jump();
    jump_en = 1; jump_addr = 8'h03; tick(); jump_en = 0; tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h03) begin bad++; $display("FAIL jump_setup valid=%b pc=%h exp=1/03", inst_valid, inst_pc); end
    delivered.delete();
    inst_ready = 0; jump_en = 1; jump_addr = 8'h20; tick(); jump_en = 0; inst_ready = 1;
    total++; if (inst_valid !== 1'b0 || imem_addr !== 8'h20) begin bad++; $display("FAIL jump_flush valid=%b addr=%h exp=0/20", inst_valid, imem_addr); end
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h20 || inst_out !== 8'h30) begin bad++; $display("FAIL jump_target valid=%b pc=%h inst=%h exp=1/20/30", inst_valid, inst_pc, inst_out); end
    total++; if (delivered.size() != 0) begin bad++; $display("FAIL jump_dropped got=%0d exp=0", delivered.size()); end
  endtask

  task automatic test_wrap();
    jump_en = 1; jump_addr = 8'hFF; tick(); jump_en = 0; tick();
    total++; if (inst_pc !== 8'hFF || inst_out !== 8'h0F) begin bad++; $display("FAIL wrap_last pc=%h inst=%h exp=ff/0f", inst_pc, inst_out); end
    tick();
    total++; if (inst_pc !== 8'h00 || inst_out !== 8'h10 || imem_addr !== 8'h01) begin bad++; $display("FAIL wrap_zero pc=%h inst=%h addr=%h exp=00/10/01", inst_pc, inst_out, imem_addr); end
  endtask

  task automatic test_halt_jump();
    halt = 1; jump_en = 1; jump_addr = 8'h40; tick(); halt = 0; jump_en = 0;
    total++; if (inst_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'h01) begin bad++; $display("FAIL halt_prio valid=%b busy=%b addr=%h exp=0/0/01", inst_valid, busy, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      jump_en = 1; tick(); jump_en = 0;
      total++; if (inst_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'h01) begin bad++; $display("FAIL halted_%0d valid=%b busy=%b addr=%h exp=0/0/01", k, inst_valid, busy, imem_addr); end
    end
    start = 1; tick(); start = 0;
    total++; if (busy !== 1'b1 || imem_addr !== 8'h00 || inst_valid !== 1'b0) begin bad++; $display("FAIL resume busy=%b addr=%h valid=%b exp=1/00/0", busy, imem_addr, inst_valid); end
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00 || inst_out !== 8'h10) begin bad++; $display("FAIL resume_first valid=%b pc=%h inst=%h exp=1/00/10", inst_valid, inst_pc, inst_out); end
  endtask

  task automatic test_reset_mid();
    inst_ready = 0; tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00) begin bad++; $display("FAIL rmid_setup valid=%b pc=%h exp=1/00", inst_valid, inst_pc); end
    reset = 1; jump_en = 1; jump_addr = 8'h55; tick(); reset = 0;
    total++; if (inst_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'h00 || inst_out !== 8'h00 || inst_pc !== 8'h00) begin
      bad++; $display("FAIL rmid_values valid=%b busy=%b addr=%h inst=%h pc=%h exp=0/0/00/00/00", inst_valid, busy, imem_addr, inst_out, inst_pc); end
    tick(); jump_en = 0;
    total++; if (busy !== 1'b0 || imem_addr !== 8'h00) begin bad++; $display("FAIL rmid_idle busy=%b addr=%h exp=0/00", busy, imem_addr); end
    inst_ready = 1; start = 1; tick(); start = 0; tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00 || inst_out !== 8'h10) begin bad++; $display("FAIL rmid_restart valid=%b pc=%h inst=%h exp=1/00/10", inst_valid, inst_pc, inst_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int c = 0; c < 2000; c++) begin
      reset      = ($urandom_range(63) == 0);
      start      = ($urandom_range(7) == 0);
      halt       = ($urandom_range(31) == 0);
      jump_en    = ($urandom_range(15) == 0);
      jump_addr  = 8'($urandom);
      inst_ready = ($urandom_range(3) != 0);
      tick();
      total++; if (busy !== m_run || inst_valid !== m_vld || imem_addr !== m_pc) begin
        bad++; $display("FAIL rand_ctl cyc=%0d busy=%b valid=%b addr=%h exp=%b/%b/%h", c, busy, inst_valid, imem_addr, m_run, m_vld, m_pc); end
      if (m_vld) begin
        total++; if (inst_pc !== m_ipc || inst_out !== m_out) begin
          bad++; $display("FAIL rand_data cyc=%0d pc=%h inst=%h exp=%h/%h", c, inst_pc, inst_out, m_ipc, m_out); end
      end
    end
    reset = 0; start = 0; halt = 0; jump_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_wrap();
    test_halt_jump();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
